// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode types and widths
// Purpose: common field width and entry record used by fetch, the fetch/decode
//          queue and decode.
// Contents: W_data_arh (field width), fetch_entry_t {instruct, pc, spec}.
package fetch_pkg;

  localparam int W_data_arh = 32;

  typedef struct packed {
    logic [W_data_arh-1:0] instruct;
    logic [W_data_arh-1:0] pc;
    logic [W_data_arh-1:0] spec;
  } fetch_entry_t;

endpackage

// File: rtl/fdq_mem.sv
// rtl/fdq_mem.sv - fetch/decode queue storage array
// Purpose: DEPTH x fetch_entry_t register array, one synchronous write port and
//          one asynchronous read port. Contents are not reset.
// Ports:
//   clock    in  rising-edge clock
//   wr_en    in  write strobe
//   wr_addr  in  write index
//   wr_data  in  entry to store
//   rd_addr  in  read index
//   rd_data  out entry at rd_addr (combinational)
module fdq_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int W_ptr = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [W_ptr-1:0]   wr_addr,
  input  fetch_entry_t       wr_data,
  input  logic [W_ptr-1:0]   rd_addr,
  output fetch_entry_t       rd_data
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - instruction buffer between fetch and decode
// Purpose: captures {instruct, pc, spec} from fetch, holds up to DEPTH entries in
//          FIFO order, presents the oldest to decode with valid/ready, back-pressures
//          fetch when full, and flushes on clear.
// Optional feature: define FDQ_BYPASS_EN for a zero-latency path from in_* to out_*
//          while the queue is empty.
// Ports:
//   clock, reset_n                       clock, async active-low reset
//   clear                                synchronous flush
//   in_valid, in_instruct, in_pc, in_spec  entry from fetch
//   stall_fetch                          queue full, fetch must hold
//   out_valid, out_instruct, out_pc, out_spec  head entry to decode
//   out_ready                            decode accepts head
//   count                                occupancy 0..DEPTH
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int W_ptr = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [W_data_arh-1:0] in_instruct,
  input  logic [W_data_arh-1:0] in_pc,
  input  logic [W_data_arh-1:0] in_spec,
  output logic                  stall_fetch,
  output logic                  out_valid,
  output logic [W_data_arh-1:0] out_instruct,
  output logic [W_data_arh-1:0] out_pc,
  output logic [W_data_arh-1:0] out_spec,
  input  logic                  out_ready,
  output logic [W_ptr:0]        count
);

  logic [W_ptr-1:0] wr_ptr;
  logic [W_ptr-1:0] rd_ptr;
  logic [W_ptr:0]   count_q;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             wr_en;
  logic             pop_mem;
  fetch_entry_t     in_entry;
  fetch_entry_t     head;
  fetch_entry_t     out_entry;

  assign in_entry = '{instruct: in_instruct, pc: in_pc, spec: in_spec};

  // Full/empty come from the registered count only, so stall has no path from out_ready.
  assign full  = (count_q == (W_ptr + 1)'(DEPTH));
  assign empty = (count_q == '0);

`ifdef FDQ_BYPASS_EN
  assign bypass = empty & in_valid & ~clear;
`else
  assign bypass = 1'b0;
`endif

  assign push    = in_valid & ~full & ~clear;
  // A bypassed entry that decode takes immediately never lands in storage.
  assign wr_en   = push & ~(bypass & out_ready);
  assign pop_mem = ~empty & out_ready & ~clear;

  fdq_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_comb begin
    out_entry = '0;
    if (bypass) begin
      out_entry = in_entry;
    end else if (!empty) begin
      out_entry = head;
    end
  end

  assign out_valid    = ~empty | bypass;
  assign out_instruct = out_entry.instruct;
  assign out_pc       = out_entry.pc;
  assign out_spec     = out_entry.spec;
  assign stall_fetch  = full;
  assign count        = count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + W_ptr'(1);
      end
      if (pop_mem) begin
        rd_ptr <= rd_ptr + W_ptr'(1);
      end
      case ({wr_en, pop_mem})
        2'b10:   count_q <= count_q + (W_ptr + 1)'(1);
        2'b01:   count_q <= count_q - (W_ptr + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - scoreboard bench for fetch_decode_queue
module tb_fetch_decode_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  clear = 1'b0;
  logic                  in_valid = 1'b0;
  logic [W_data_arh-1:0] in_instruct = '0;
  logic [W_data_arh-1:0] in_pc = '0;
  logic [W_data_arh-1:0] in_spec = '0;
  logic                  stall_fetch;
  logic                  out_valid;
  logic [W_data_arh-1:0] out_instruct;
  logic [W_data_arh-1:0] out_pc;
  logic [W_data_arh-1:0] out_spec;
  logic                  out_ready = 1'b0;
  logic [2:0]            count;

  int checks = 0;
  int failures = 0;
  int mcount = 0;
  logic [31:0] sb[$];

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_instruct  (in_instruct),
    .in_pc        (in_pc),
    .in_spec      (in_spec),
    .stall_fetch  (stall_fetch),
    .out_valid    (out_valid),
    .out_instruct (out_instruct),
    .out_pc       (out_pc),
    .out_spec     (out_spec),
    .out_ready    (out_ready),
    .count        (count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] spec_of(input logic [31:0] pc);
    return pc + 32'd7;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instruct, instr_of(pc));
    check({tag, "_spec"}, out_spec, spec_of(pc));
  endtask

  // One cycle: drive at negedge, check outputs against the model, update the model;
  // the DUT commits at the following posedge.
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic rdy, input logic clr);
    bit byp;
    bit pop;
    bit push;
    @(negedge clock);
    in_valid    = iv;
    in_pc       = pc;
    in_instruct = instr_of(pc);
    in_spec     = spec_of(pc);
    out_ready   = rdy;
    clear       = clr;
    #1;
    check("count", 32'(count), 32'(mcount));
    check("stall", 32'(stall_fetch), 32'(mcount == DEPTH));
    byp = BYP && (mcount == 0) && iv && !clr;
    if (clr) begin
      sb.delete();
      mcount = 0;
    end else begin
      check("out_valid", 32'(out_valid), 32'((mcount != 0) || byp));
      if (byp) begin
        check_head("bypass", pc);
      end else if (mcount != 0) begin
        check_head("head", sb[0]);
      end else begin
        check("idle_pc", out_pc, 32'd0);
      end
      pop  = rdy && (mcount != 0);
      push = iv && (mcount != DEPTH);
      if (byp) begin
        if (!rdy) begin
          sb.push_back(pc);
          mcount++;
        end
      end else begin
        if (pop) begin
          void'(sb.pop_front());
          mcount--;
        end
        if (push) begin
          sb.push_back(pc);
          mcount++;
        end
      end
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    // Reset values while reset_n is held low
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_stall", 32'(stall_fetch), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instruct, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Fill to full, fifth push refused, drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Full with simultaneous pop and push: pop only, stall drops next cycle
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h20 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'h30, 1'b1, 1'b0);
    idle(1'b0);
    check("fp_count", 32'(count), 32'd3);
    check("fp_stall", 32'(stall_fetch), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      check("wrap_le1", 32'(count <= 3'd1), 32'd1);
    end
    idle(1'b1);
    idle(1'b0);

    // Clear with concurrent push and pop, then fresh push becomes head
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h180 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'h1F0, 1'b1, 1'b1);
    idle(1'b0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Empty push with ready: latency 0 with bypass, 1 without
    cycle(1'b1, 32'h40, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Asynchronous reset mid-operation discards entries
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 1'b0, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    mcount = 0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
